// File: rtl/sklansky_pkg.sv
// Shared types and helpers for the multi-precision Sklansky add sequencer.
// Holds slice width, sequencer state encoding and the overflow helper.
package sklansky_pkg;

   localparam int SLICE_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mp_state_t;

   // Signed overflow: like-signed operands giving an opposite-signed result.
   function automatic logic ovf_calc(
      input logic a_msb,
      input logic b_msb,
      input logic s_msb
   );
      return (a_msb == b_msb) && (s_msb != a_msb);
   endfunction

endpackage

// File: rtl/sklansky.sv
// 16-bit Sklansky parallel-prefix adder.
// Ports: a, b, cin in; sum, cout out. Purely combinational.
module sklansky
   import sklansky_pkg::*;
(
   input  logic [SLICE_W-1:0] a,
   input  logic [SLICE_W-1:0] b,
   input  logic               cin,
   output logic [SLICE_W-1:0] sum,
   output logic               cout
);

   localparam int LVLS = 4;

   // gl/pl[l][i]: group generate/propagate of bits [base..i] after level l.
   logic [LVLS:0][SLICE_W-1:0] gl;
   logic [LVLS:0][SLICE_W-1:0] pl;
   logic [SLICE_W-1:0]         c;

   assign gl[0] = a & b;
   assign pl[0] = a ^ b;

   for (genvar l = 0; l < LVLS; l++) begin : g_lvl
      for (genvar i = 0; i < SLICE_W; i++) begin : g_bit
         // Bits in the upper half of each 2^(l+1) block combine with the
         // top bit of the lower half (Sklansky fan-out pattern).
         if (((i >> l) & 1) == 1) begin : g_cmb
            localparam int J = ((i >> l) << l) - 1;
            assign gl[l+1][i] = gl[l][i] | (pl[l][i] & gl[l][J]);
            assign pl[l+1][i] = pl[l][i] & pl[l][J];
         end else begin : g_pass
            assign gl[l+1][i] = gl[l][i];
            assign pl[l+1][i] = pl[l][i];
         end
      end
   end

   assign c[0] = cin;
   for (genvar i = 1; i < SLICE_W; i++) begin : g_c
      assign c[i] = gl[LVLS][i-1] | (pl[LVLS][i-1] & cin);
   end

   assign sum  = pl[0] ^ c;
   assign cout = gl[LVLS][SLICE_W-1] | (pl[LVLS][SLICE_W-1] & cin);

endmodule

// File: rtl/sklansky_mp_seq.sv
// Multi-precision add sequencer: WORDS x 16-bit slices through one sklansky.
// Ports: in_valid/in_ready/a/b/cin[/sub] in, out_valid/out_ready/sum/cout/ovf out, busy.
// SKLANSKY_MP_SUB_EN adds the sub port (a - b via ~b and carry-in 1).
module sklansky_mp_seq
   import sklansky_pkg::*;
#(
   parameter int WORDS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [SLICE_W*WORDS-1:0] a,
   input  logic [SLICE_W*WORDS-1:0] b,
   input  logic                  cin,
`ifdef SKLANSKY_MP_SUB_EN
   input  logic                  sub,
`endif
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [SLICE_W*WORDS-1:0] sum,
   output logic                  cout,
   output logic                  ovf,
   output logic                  busy
);

   localparam int IW = $clog2(WORDS);

   typedef logic [WORDS-1:0][SLICE_W-1:0] wide_t;

   mp_state_t   state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   wide_t       a_q, a_d;
   wide_t       b_q, b_d;
   wide_t       sum_q, sum_d;
   logic        carry_q, carry_d;
   logic        cout_q, cout_d;
   logic        ovf_q, ovf_d;

   logic [SLICE_W*WORDS-1:0] b_eff;
   logic        c_init;
   logic [SLICE_W-1:0] s_sl;
   logic        s_co;
   logic        last;

`ifdef SKLANSKY_MP_SUB_EN
   assign b_eff  = sub ? ~b : b;
   assign c_init = sub ? 1'b1 : cin;
`else
   assign b_eff  = b;
   assign c_init = cin;
`endif

   sklansky u_add (
      .a    (a_q[idx_q]),
      .b    (b_q[idx_q]),
      .cin  (carry_q),
      .sum  (s_sl),
      .cout (s_co)
   );

   assign last = (idx_q == IW'(WORDS - 1));

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b_eff;
               carry_d = c_init;
               idx_d   = '0;
               sum_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            sum_d[idx_q] = s_sl;
            carry_d      = s_co;
            if (last) begin
               cout_d  = s_co;
               ovf_d   = ovf_calc(a_q[WORDS-1][SLICE_W-1],
                                  b_q[WORDS-1][SLICE_W-1],
                                  s_sl[SLICE_W-1]);
               state_d = DONE;
            end else begin
               idx_d = idx_q + IW'(1);
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_sklansky_mp_seq.sv
// Self-checking bench for sklansky_mp_seq (WORDS=4, plus a WORDS=2 smoke).
// Reference: plain wide-integer add of a, b_eff and carry-in.
module tb_sklansky_mp_seq;

   localparam int WORDS = 4;
   localparam int W     = 16 * WORDS;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic          cin = 1'b0;
   logic          sub_i = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  sum;
   logic          cout;
   logic          ovf;
   logic          busy;

   logic          in_valid2 = 1'b0;
   logic          in_ready2;
   logic [31:0]   a2 = '0;
   logic [31:0]   b2 = '0;
   logic          out_valid2;
   logic          out_ready2 = 1'b0;
   logic [31:0]   sum2;
   logic          cout2;
   logic          ovf2;
   logic          busy2;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   sklansky_mp_seq #(.WORDS(WORDS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
`ifdef SKLANSKY_MP_SUB_EN
      .sub       (sub_i),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf),
      .busy      (busy)
   );

   sklansky_mp_seq #(.WORDS(2)) dut2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid2),
      .in_ready  (in_ready2),
      .a         (a2),
      .b         (b2),
      .cin       (1'b0),
`ifdef SKLANSKY_MP_SUB_EN
      .sub       (1'b0),
`endif
      .out_valid (out_valid2),
      .out_ready (out_ready2),
      .sum       (sum2),
      .cout      (cout2),
      .ovf       (ovf2),
      .busy      (busy2)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // One transaction; hold>0 keeps out_ready low that many DONE cycles
   // while offering a competing operand on in_valid.
   task automatic add_chk(input string tag, input logic [W-1:0] av,
                          input logic [W-1:0] bv, input logic ci,
                          input logic sb, input int hold);
      logic [W:0]   full;
      logic [W-1:0] be;
      logic         e_ovf;
      int           lat;
      be    = sb ? ~bv : bv;
      full  = {1'b0, av} + {1'b0, be} + (W+1)'(sb ? 1'b1 : ci);
      e_ovf = (av[W-1] == be[W-1]) && (full[W-1] != av[W-1]);
      chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
      a = av; b = bv; cin = ci; sub_i = sb; in_valid = 1'b1;
      step;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         step;
         lat++;
      end
      chk({tag, ".lat"}, 64'(lat), 64'(WORDS));
      chk({tag, ".sum"}, sum, full[W-1:0]);
      chk({tag, ".cout"}, 64'(cout), 64'(full[W]));
      chk({tag, ".ovf"}, 64'(ovf), 64'(e_ovf));
      if (hold > 0) begin
         a = ~av; b = bv ^ 64'h1234; in_valid = 1'b1;
         for (int k = 0; k < hold; k++) begin
            step;
            chk({tag, ".hold_sum"}, sum, full[W-1:0]);
            chk({tag, ".hold_cout"}, 64'(cout), 64'(full[W]));
            chk({tag, ".hold_ovf"}, 64'(ovf), 64'(e_ovf));
            chk({tag, ".hold_rdy"}, 64'(in_ready), 64'd0);
            chk({tag, ".hold_ov"}, 64'(out_valid), 64'd1);
         end
      end
      out_ready = 1'b1;
      step;
      out_ready = 1'b0;
      in_valid = 1'b0;
      chk({tag, ".post_ov"}, 64'(out_valid), 64'd0);
      chk({tag, ".post_rdy"}, 64'(in_ready), 64'd1);
      chk({tag, ".post_busy"}, 64'(busy), 64'd0);
   endtask

   initial begin
      int lat;
      logic [W-1:0] ra, rb;
      rst_n = 1'b0;
      step;
      step;
      chk("rst.in_ready", 64'(in_ready), 64'd1);
      chk("rst.out_valid", 64'(out_valid), 64'd0);
      chk("rst.busy", 64'(busy), 64'd0);
      chk("rst.sum", sum, 64'd0);
      chk("rst.cout", 64'(cout), 64'd0);
      chk("rst.ovf", 64'(ovf), 64'd0);
      rst_n = 1'b1;
      step;

      add_chk("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 0);
      chk("ripple.const", sum, 64'd0);
      add_chk("bound", 64'h0000_FFFF_0000_FFFF, 64'd1, 1'b0, 1'b0, 0);
      chk("bound.const", sum, 64'h0000_FFFF_0001_0000);
      add_chk("cin", 64'd0, 64'd0, 1'b1, 1'b0, 0);
      chk("cin.const", sum, 64'd1);
      add_chk("ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 0);
      chk("ovf.const", 64'(ovf), 64'd1);
      add_chk("bp", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321,
              1'b1, 1'b0, 3);

      // Reset on the second RUN cycle abandons the operation.
      a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'hFFFF_FFFF_FFFF_FFFF;
      cin = 1'b1; sub_i = 1'b0; in_valid = 1'b1;
      step;
      in_valid = 1'b0;
      step;
      rst_n = 1'b0;
      step;
      rst_n = 1'b1;
      chk("mrst.out_valid", 64'(out_valid), 64'd0);
      chk("mrst.sum", sum, 64'd0);
      chk("mrst.busy", 64'(busy), 64'd0);
      chk("mrst.in_ready", 64'(in_ready), 64'd1);
      lat = 0;
      repeat (6) begin
         step;
         if (out_valid) lat++;
      end
      chk("mrst.no_out", 64'(lat), 64'd0);
      add_chk("mrst.fresh", 64'h0000_0001_8000_0000, 64'h0000_0002_8000_0000,
              1'b0, 1'b0, 0);

      for (int n = 0; n < 24; n++) begin
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         if (n % 4 == 0) rb = ~ra;
         add_chk("rnd", ra, rb, 1'($urandom), 1'b0, int'($urandom_range(0, 2)));
      end

`ifdef SKLANSKY_MP_SUB_EN
      add_chk("sub57", 64'd5, 64'd7, 1'b0, 1'b1, 0);
      chk("sub57.const", sum, 64'hFFFF_FFFF_FFFF_FFFE);
      chk("sub57.cout", 64'(cout), 64'd0);
      add_chk("sub75", 64'd7, 64'd5, 1'b0, 1'b1, 0);
      chk("sub75.const", sum, 64'd2);
      chk("sub75.cout", 64'(cout), 64'd1);
      for (int n = 0; n < 12; n++) begin
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         add_chk("rsub", ra, rb, 1'($urandom), 1'($urandom), 0);
      end
`endif

      // WORDS=2 smoke run.
      chk("w2.in_ready", 64'(in_ready2), 64'd1);
      a2 = 32'hFFFF_FFFF; b2 = 32'd1; in_valid2 = 1'b1;
      step;
      in_valid2 = 1'b0;
      lat = 0;
      while (!out_valid2 && lat < 20) begin
         step;
         lat++;
      end
      chk("w2.lat", 64'(lat), 64'd2);
      chk("w2.sum", 64'(sum2), 64'd0);
      chk("w2.cout", 64'(cout2), 64'd1);
      chk("w2.ovf", 64'(ovf2), 64'd0);
      chk("w2.busy", 64'(busy2), 64'd1);
      out_ready2 = 1'b1;
      step;
      out_ready2 = 1'b0;
      chk("w2.post_rdy", 64'(in_ready2), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sklansky_mp_seq.md
# sklansky_mp_seq

Multi-precision add sequencer that time-shares a single 16-bit `sklansky` prefix adder to add `WORDS`×16-bit operands, one 16-bit slice per clock. The carry is chained through a register between slices. Operands enter and results leave through valid/ready handshakes. It sits between a wide-datapath client (e.g. a bignum/accumulator unit) and the existing 16-bit adder, trading latency for area.

## Interface
- `WORDS`, default 4: number of 16-bit slices, legal range 2..16; operand width W = 16*WORDS.
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: synchronous, active-low reset.
- `in_valid`  in  1: operand beat valid.
- `in_ready`  out  1: block can accept operands.
- `a`  in  W: operand A.
- `b`  in  W: operand B.
- `cin`  in  1: carry into slice 0 (add mode).
- `sub`  in  1: subtract request; present only with `SKLANSKY_MP_SUB_EN`.
- `out_valid`  out  1: result valid.
- `out_ready`  in  1: consumer accepts result.
- `sum`  out  W: result.
- `cout`  out  1: carry out of MSB slice.
- `ovf`  out  1: two's-complement overflow of the W-bit result.
- `busy`  out  1: high in RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&`in_ready`: latch `a` and `b_eff` into operand registers; carry register := `cin` (or 1 if subtracting); slice index `idx`:=0; clear `sum` register; go to RUN.
- RUN: one slice per cycle.
  - Adder inputs: `a[16*idx +: 16]`, `b_eff[16*idx +: 16]`, carry register.
  - Registered updates: `sum[16*idx +: 16]`, carry register := adder cout, `idx`++.
  - When `idx`==WORDS-1, transition to DONE in the same edge.
- DONE:
  - `out_valid`=1.
  - `sum`, `cout`, `ovf` stable and held.
  - On `out_ready`: return to IDLE.
  - `in_ready`=0 throughout DONE; no operand is accepted in the same cycle as result handoff.
- `ovf` = (a[W-1] == b_eff[W-1]) & (sum[W-1] != a[W-1]), registered on the last RUN cycle.
- `cout` = carry register after the last slice.
- `idx` width: $clog2(WORDS). It never wraps beyond WORDS-1.
- `in_valid` in RUN/DONE is ignored. Operands must be held by the sender until accepted (standard valid/ready).

## Timing
- Reset (`rst_n`=0 at a clock edge): state:=IDLE, `idx`:=0, carry:=0, `sum`:=0, `cout`:=0, `ovf`:=0.
  - Resulting outputs: `out_valid`=0, `busy`=0, `in_ready`=1.
  - Reset mid-RUN or mid-DONE abandons the operation, with no partial output.
- Accept at edge E0.
- RUN occupies cycles E0+1..E0+WORDS.
- `out_valid` rises after edge E0+WORDS, i.e. WORDS cycles latency from accept.
- Minimum initiation interval: WORDS+2 cycles (RUN ×WORDS, DONE ≥1, IDLE ≥1).
- `in_ready`, `out_valid` and `busy` are decoded combinationally from the state register only. There are no combinational paths from inputs to outputs.
- Critical path: one 16-bit `sklansky` plus operand slice mux plus carry register.

## Configuration
- Macro: `SKLANSKY_MP_SUB_EN`.
- Defined:
  - `sub` port exists.
  - When `sub`=1 at accept: `b_eff`=~b, initial carry=1, `cin` ignored; result is a−b, and `cout`=1 means no borrow.
  - When `sub`=0: `b_eff`=b, initial carry=`cin`.
- Undefined:
  - No `sub` port; `b_eff`=b always, initial carry=`cin`.

## Structure
- Shared package `sklansky_pkg`:
  - `SLICE_W`=16.
  - State enum `mp_state_t` {IDLE, RUN, DONE}.
  - Function `ovf_calc(a_msb, b_msb, s_msb)`.
- One sub-module instance: existing `sklansky` (16-bit, `a`/`b`/`cin`/`sum`/`cout`). It is instantiated once; there is no other hierarchy.

## Test plan
All with WORDS=4 unless noted.
- Carry ripple through all slices: a=64'hFFFF_FFFF_FFFF_FFFF, b=1, cin=0 → sum=0, cout=1, ovf=0, `out_valid` exactly 4 cycles after accept.
- Single boundary carry: a=64'h0000_FFFF_0000_FFFF, b=64'h0000_0000_0000_0001 → sum=64'h0000_FFFF_0001_0000, cout=0. Then `cin`=1 with a=b=0 → sum=1.
- Signed overflow: a=64'h7FFF_FFFF_FFFF_FFFF, b=1 → sum=64'h8000_0000_0000_0000, ovf=1, cout=0.
- Backpressure: hold `out_ready`=0 for 3 cycles in DONE → `sum`/`cout`/`ovf` unchanged, `in_ready`=0, a concurrent `in_valid` is not accepted. `out_ready`=1 → IDLE next cycle, `in_ready`=1.
- Reset mid-operation: drive `rst_n`=0 on the 2nd RUN cycle → next cycle IDLE, `out_valid`=0, `sum`=0, `busy`=0. A fresh add then completes correctly.
- `SKLANSKY_MP_SUB_EN` defined: a=5, b=7, sub=1 → sum=64'hFFFF_FFFF_FFFF_FFFE, cout=0. Then a=7, b=5 → sum=2, cout=1. Also WORDS=2 smoke run: a=32'hFFFF_FFFF, b=1 → sum=0, cout=1, latency 2.
